// File: rtl/p_mul_issuer_if.sv
// Handshake bundles around the packed-multiplier issuer.
//   p_mul_req_if : execute-stage request (req_*) and response (rsp_*) channels.
//                  master = execute stage, slave = issuer.
//   p_mul_bus_if : issuer-to-multiplier valid/ready transaction port (mul_*).
//                  master = issuer, slave = packed multiplier.
interface p_mul_req_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic        req_clmul;
  logic [4:0]  req_pw;
  logic [31:0] req_crs1;
  logic [31:0] req_crs2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_lo;
  logic [31:0] rsp_hi;
  logic        rsp_err;

  modport master (
    output req_valid, req_op, req_clmul, req_pw, req_crs1, req_crs2, rsp_ready,
    input  req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_clmul, req_pw, req_crs1, req_crs2, rsp_ready,
    output req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_err
  );
endinterface

interface p_mul_bus_if;
  logic        mul_valid;
  logic        mul_ready;
  logic        mul_l;
  logic        mul_h;
  logic        mul_clmul;
  logic [4:0]  mul_pw;
  logic [31:0] mul_crs1;
  logic [31:0] mul_crs2;
  logic [31:0] mul_result;

  modport master (
    output mul_valid, mul_l, mul_h, mul_clmul, mul_pw, mul_crs1, mul_crs2,
    input  mul_ready, mul_result
  );

  modport slave (
    input  mul_valid, mul_l, mul_h, mul_clmul, mul_pw, mul_crs1, mul_crs2,
    output mul_ready, mul_result
  );
endinterface

// File: rtl/p_mul_issuer.sv
// Initiator-side sequencer for the packed multiplier.
// Takes one multiply request, issues a low-word and/or high-word p_mul
// transaction, and returns the collected 64-bit result. Illegal requests
// (op==00 or pack width not one-hot) and multiplier timeouts end in an
// error response with both result words zero.
// Ports:
//   clock  : system clock
//   resetn : asynchronous active-low reset
//   req    : request/response channels (slave side)
//   mul    : p_mul valid/ready transaction port (master side)
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | req_ready=1, waiting for a request
// ISSUE_LO | mul_valid=1 with mul_l=1, waiting for mul_ready
// ISSUE_HI | mul_valid=1 with mul_h=1, waiting for mul_ready
// RESP     | rsp_valid=1, holding result until rsp_ready
module p_mul_issuer #(
  parameter int unsigned TIMEOUT   = 200,
  parameter int unsigned TIMEOUT_W = 8    // must hold TIMEOUT-1
) (
  input  logic        clock,
  input  logic        resetn,
  p_mul_req_if.slave  req,
  p_mul_bus_if.master mul
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE_LO = 2'd1,
    ISSUE_HI = 2'd2,
    RESP     = 2'd3
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TMO_LOAD = TIMEOUT_W'(TIMEOUT - 1);

  state_t state_q, state_d;

  logic [1:0]           op_q;
  logic                 clmul_q;
  logic [4:0]           pw_q;
  logic [31:0]          crs1_q;
  logic [31:0]          crs2_q;
  logic [31:0]          rsp_lo_q;
  logic [31:0]          rsp_hi_q;
  logic                 err_q;
  logic [TIMEOUT_W-1:0] tmo_cnt_q;

  logic accept;
  logic req_bad;
  logic issuing;
  logic tmo_tc;
  logic load_tmo;

  assign accept   = (state_q == IDLE) && req.req_valid;
  assign req_bad  = (req.req_op == 2'b00) || !$onehot(req.req_pw);
  assign issuing  = (state_q == ISSUE_LO) || (state_q == ISSUE_HI);
  // Terminal count only fires when the multiplier did not answer this cycle,
  // so a late mul_ready still wins over the timeout.
  assign tmo_tc   = issuing && !mul.mul_ready && (tmo_cnt_q == '0);
  // Every transition into an issue state (including LO->HI) starts a fresh
  // timeout window.
  assign load_tmo = (state_d != state_q) &&
                    ((state_d == ISSUE_LO) || (state_d == ISSUE_HI));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req.req_valid) begin
          if (req_bad)             state_d = RESP;
          else if (req.req_op[0])  state_d = ISSUE_LO;
          else                     state_d = ISSUE_HI;
        end
      end
      ISSUE_LO: begin
        if (mul.mul_ready)  state_d = op_q[1] ? ISSUE_HI : RESP;
        else if (tmo_tc)    state_d = RESP;
      end
      ISSUE_HI: begin
        if (mul.mul_ready || tmo_tc) state_d = RESP;
      end
      RESP: begin
        if (req.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req.req_ready = 1'b0;
    req.rsp_valid = 1'b0;
    mul.mul_valid = 1'b0;
    mul.mul_l     = 1'b0;
    mul.mul_h     = 1'b0;
    case (state_q)
      IDLE:     req.req_ready = 1'b1;
      ISSUE_LO: begin
        mul.mul_valid = 1'b1;
        mul.mul_l     = 1'b1;
      end
      ISSUE_HI: begin
        mul.mul_valid = 1'b1;
        mul.mul_h     = 1'b1;
      end
      RESP:     req.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign mul.mul_clmul = clmul_q;
  assign mul.mul_pw    = pw_q;
  assign mul.mul_crs1  = crs1_q;
  assign mul.mul_crs2  = crs2_q;
  assign req.rsp_lo    = rsp_lo_q;
  assign req.rsp_hi    = rsp_hi_q;
  assign req.rsp_err   = err_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      op_q     <= '0;
      clmul_q  <= 1'b0;
      pw_q     <= '0;
      crs1_q   <= '0;
      crs2_q   <= '0;
      rsp_lo_q <= '0;
      rsp_hi_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        op_q     <= req.req_op;
        clmul_q  <= req.req_clmul;
        pw_q     <= req.req_pw;
        crs1_q   <= req.req_crs1;
        crs2_q   <= req.req_crs2;
        rsp_lo_q <= '0;
        rsp_hi_q <= '0;
        err_q    <= req_bad;
      end else if (issuing) begin
        if (mul.mul_ready) begin
          if (state_q == ISSUE_LO) rsp_lo_q <= mul.mul_result;
          else                     rsp_hi_q <= mul.mul_result;
        end else if (tmo_tc) begin
          // A timed-out request reports nothing, even a low word already
          // collected.
          rsp_lo_q <= '0;
          rsp_hi_q <= '0;
          err_q    <= 1'b1;
        end
      end
    end
  end

  // Down-counter: loaded with TIMEOUT-1 on entry, terminal count at zero,
  // which gives exactly TIMEOUT cycles of mul_valid before the abort.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt_q <= '0;
    end else if (load_tmo) begin
      tmo_cnt_q <= TMO_LOAD;
    end else if (issuing && !mul.mul_ready && (tmo_cnt_q != '0)) begin
      tmo_cnt_q <= tmo_cnt_q - TIMEOUT_W'(1);
    end
  end

endmodule

// File: tb/tb_p_mul_issuer.sv
module tb_p_mul_issuer;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  p_mul_req_if req_if ();
  p_mul_bus_if mul_if ();

  p_mul_issuer #(.TIMEOUT(200), .TIMEOUT_W(8)) dut (
    .clock  (clock),
    .resetn (resetn),
    .req    (req_if),
    .mul    (mul_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // multiplier model controls and observations
  int         lat_fix  = -1;   // -1: random 0..3 cycles before ready
  int         hs_allow = 99;   // handshakes the model will grant this request
  int         hs_done  = 0;
  int         valid_cyc = 0;
  int         stab_err = 0;
  logic [1:0] hs_q[$];         // {mul_l, mul_h} of each handshake, in order
  logic       new_txn = 1'b1;
  int         busy_cyc = 0;
  int         lat_cur = 0;
  logic [71:0] snap;

  typedef struct {
    logic [1:0]  op;
    logic        clmul;
    logic [4:0]  pw;
    logic [31:0] crs1;
    logic [31:0] crs2;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    logic        exp_err;
    logic [3:0]  exp_hs;
    int          exp_cnt;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Packed multiply reference: independent lanes of width W, low or high
  // half of each 2W-bit lane product.
  function automatic logic [31:0] pmul(input logic [31:0] a, input logic [31:0] b,
                                       input logic [4:0] pw, input logic clmul,
                                       input logic hi);
    int w;
    longint unsigned mask, x, y, p;
    logic [31:0] r;
    case (pw)
      5'b00001: w = 32;
      5'b00010: w = 16;
      5'b00100: w = 8;
      5'b01000: w = 4;
      default:  w = 2;
    endcase
    mask = (64'd1 << w) - 64'd1;
    r = '0;
    for (int i = 0; i < 32 / w; i++) begin
      x = ({32'd0, a} >> (i * w)) & mask;
      y = ({32'd0, b} >> (i * w)) & mask;
      if (clmul) begin
        p = 0;
        for (int j = 0; j < w; j++) if (y[j]) p = p ^ (x << j);
      end else begin
        p = x * y;
      end
      r = r | (32'((hi ? (p >> w) : p) & mask) << (i * w));
    end
    return r;
  endfunction

  function automatic logic [3:0] enc_hs(input logic [1:0] q[$]);
    logic [3:0] c;
    c = '0;
    foreach (q[i]) c = {c[1:0], q[i]};
    return c;
  endfunction

  task automatic model_rsp(input logic [1:0] op, input logic clmul, input logic [4:0] pw,
                           input logic [31:0] c1, input logic [31:0] c2,
                           output logic [31:0] lo, output logic [31:0] hi, output logic err,
                           output logic [3:0] hs, output int cnt);
    logic [1:0] q[$];
    lo = '0; hi = '0;
    err = (op == 2'b00) || !$onehot(pw);
    if (!err) begin
      if (op[0]) begin lo = pmul(c1, c2, pw, clmul, 1'b0); q.push_back(2'b10); end
      if (op[1]) begin hi = pmul(c1, c2, pw, clmul, 1'b1); q.push_back(2'b01); end
    end
    hs  = enc_hs(q);
    cnt = q.size();
  endtask

  // Multiplier responder + monitor, working on the falling edge.
  always @(negedge clock) begin
    if (!resetn) begin
      mul_if.mul_ready  = 1'b0;
      mul_if.mul_result = '0;
      new_txn = 1'b1;
      busy_cyc = 0;
    end else if (mul_if.mul_valid) begin
      valid_cyc++;
      if (new_txn) begin
        snap = {mul_if.mul_l, mul_if.mul_h, mul_if.mul_clmul, mul_if.mul_pw,
                mul_if.mul_crs1, mul_if.mul_crs2};
        lat_cur = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
        busy_cyc = 0;
        new_txn = 1'b0;
      end else if ({mul_if.mul_l, mul_if.mul_h, mul_if.mul_clmul, mul_if.mul_pw,
                    mul_if.mul_crs1, mul_if.mul_crs2} !== snap) begin
        stab_err++;
      end
      if (hs_done < hs_allow && busy_cyc >= lat_cur) begin
        mul_if.mul_ready  = 1'b1;
        mul_if.mul_result = pmul(mul_if.mul_crs1, mul_if.mul_crs2, mul_if.mul_pw,
                                 mul_if.mul_clmul, mul_if.mul_h);
        hs_q.push_back({mul_if.mul_l, mul_if.mul_h});
        hs_done++;
        new_txn = 1'b1;
      end else begin
        mul_if.mul_ready  = 1'b0;
        mul_if.mul_result = $urandom;
      end
      busy_cyc++;
    end else begin
      mul_if.mul_ready  = 1'b0;
      mul_if.mul_result = $urandom;
      new_txn = 1'b1;
      if (mul_if.mul_l || mul_if.mul_h) stab_err++;
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_req_ready"}, req_if.req_ready, 1);
    check({tag, "_ctl"}, {mul_if.mul_valid, mul_if.mul_l, mul_if.mul_h,
                          req_if.rsp_valid, req_if.rsp_err, mul_if.mul_clmul}, 0);
    check({tag, "_rsp"}, {req_if.rsp_lo, req_if.rsp_hi}, 0);
    check({tag, "_mul_op"}, {mul_if.mul_pw, mul_if.mul_crs1, mul_if.mul_crs2}, 0);
  endtask

  // Call on a falling edge with the DUT idle; returns on a falling edge.
  task automatic run_req(input logic [1:0] op, input logic clmul, input logic [4:0] pw,
                         input logic [31:0] c1, input logic [31:0] c2, input int hold,
                         output logic [31:0] lo, output logic [31:0] hi,
                         output logic err, output int lat);
    int guard;
    int hold_err;
    hs_q.delete(); hs_done = 0; valid_cyc = 0; stab_err = 0;
    req_if.req_op = op; req_if.req_clmul = clmul; req_if.req_pw = pw;
    req_if.req_crs1 = c1; req_if.req_crs2 = c2;
    req_if.req_valid = 1'b1;
    guard = 0;
    while (!req_if.req_ready && guard < 100) begin @(negedge clock); guard++; end
    if (!req_if.req_ready) begin
      n_tests++; n_fail++;
      $display("FAIL accept: req_ready still 0 after %0d cycles, required 1", guard);
    end
    @(negedge clock);
    req_if.req_valid = 1'b0;
    lat = 1;
    while (!req_if.rsp_valid && lat < 1000) begin @(negedge clock); lat++; end
    if (!req_if.rsp_valid) begin
      n_tests++; n_fail++;
      $display("FAIL rsp_wait: rsp_valid 0 after %0d cycles, required 1", lat);
    end
    lo = req_if.rsp_lo; hi = req_if.rsp_hi; err = req_if.rsp_err;
    hold_err = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      if (req_if.rsp_lo !== lo || req_if.rsp_hi !== hi || req_if.rsp_err !== err ||
          req_if.rsp_valid !== 1'b1 || req_if.req_ready !== 1'b0) hold_err++;
    end
    if (hold > 0) check("rsp_hold", hold_err, 0);
    req_if.rsp_ready = 1'b1;
    @(negedge clock);
    req_if.rsp_ready = 1'b0;
    check("back_to_idle", {req_if.req_ready, req_if.rsp_valid}, 2'b10);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[9];
    logic [31:0] lo, hi, elo, ehi;
    logic        err, eerr;
    logic [3:0]  ehs;
    int          ecnt, lat;
    logic [1:0]  op;
    logic [4:0]  pw;
    logic        clmul;
    logic [31:0] c1, c2;

    vecs[0] = '{2'b11, 1'b0, 5'b00001, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h00000001, 1'b0, 4'b1001, 2, 3};
    vecs[1] = '{2'b01, 1'b0, 5'b00010, 32'h00030002, 32'h00050004, 32'h000F0008, 32'h0, 1'b0, 4'b0010, 1, 2};
    vecs[2] = '{2'b10, 1'b1, 5'b00001, 32'h3, 32'h3, 32'h0, 32'h0, 1'b0, 4'b0001, 1, 2};
    vecs[3] = '{2'b01, 1'b1, 5'b00001, 32'h3, 32'h3, 32'h5, 32'h0, 1'b0, 4'b0010, 1, 2};
    vecs[4] = '{2'b11, 1'b0, 5'b00011, 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0, 1'b1, 4'b0000, 0, 1};
    vecs[5] = '{2'b00, 1'b0, 5'b00001, 32'h11111111, 32'h22222222, 32'h0, 32'h0, 1'b1, 4'b0000, 0, 1};
    vecs[6] = '{2'b01, 1'b0, 5'b00000, 32'h5, 32'h6, 32'h0, 32'h0, 1'b1, 4'b0000, 0, 1};
    vecs[7] = '{2'b11, 1'b0, 5'b10000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555, 32'hAAAAAAAA, 1'b0, 4'b1001, 2, 3};
    vecs[8] = '{2'b11, 1'b1, 5'b01000, 32'h0000000F, 32'h0000000F, 32'h5, 32'h5, 1'b0, 4'b1001, 2, 3};

    resetn = 1'b0;
    req_if.req_valid = 1'b0; req_if.req_op = '0; req_if.req_clmul = 1'b0;
    req_if.req_pw = '0; req_if.req_crs1 = '0; req_if.req_crs2 = '0;
    req_if.rsp_ready = 1'b0;
    #12;
    check_reset("por");
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check_reset("post_rst");

    // directed vectors with a 1-cycle multiplier
    lat_fix = 0; hs_allow = 99;
    foreach (vecs[i]) begin
      run_req(vecs[i].op, vecs[i].clmul, vecs[i].pw, vecs[i].crs1, vecs[i].crs2, 0,
              lo, hi, err, lat);
      check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
      check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("v%0d_err", i), err, vecs[i].exp_err);
      check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_hs", i), enc_hs(hs_q), vecs[i].exp_hs);
      check($sformatf("v%0d_hs_cnt", i), hs_q.size(), vecs[i].exp_cnt);
      check($sformatf("v%0d_valid_cyc", i), valid_cyc, vecs[i].exp_cnt);
      check($sformatf("v%0d_stable", i), stab_err, 0);
    end

    // randomized requests, random multiplier latency and response back-pressure
    lat_fix = -1;
    for (int n = 0; n < 40; n++) begin
      op    = 2'($urandom_range(0, 3));
      clmul = 1'($urandom);
      pw    = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'(1 << $urandom_range(0, 4));
      c1    = $urandom;
      c2    = $urandom;
      model_rsp(op, clmul, pw, c1, c2, elo, ehi, eerr, ehs, ecnt);
      run_req(op, clmul, pw, c1, c2, int'($urandom_range(0, 3)), lo, hi, err, lat);
      check($sformatf("r%0d_lo", n), lo, elo);
      check($sformatf("r%0d_hi", n), hi, ehi);
      check($sformatf("r%0d_err", n), err, eerr);
      check($sformatf("r%0d_hs", n), enc_hs(hs_q), ehs);
      check($sformatf("r%0d_hs_cnt", n), hs_q.size(), ecnt);
      check($sformatf("r%0d_stable", n), stab_err, 0);
    end

    // response held off for 5 cycles
    lat_fix = 0;
    run_req(2'b11, 1'b0, 5'b00100, 32'h01020304, 32'h05060708, 5, lo, hi, err, lat);
    model_rsp(2'b11, 1'b0, 5'b00100, 32'h01020304, 32'h05060708, elo, ehi, eerr, ehs, ecnt);
    check("hold5_lo", lo, elo);
    check("hold5_hi", hi, ehi);

    // multiplier never answers: exactly 200 cycles of mul_valid, then error
    hs_allow = 0;
    run_req(2'b01, 1'b0, 5'b00100, 32'hDEADBEEF, 32'hCAFEF00D, 0, lo, hi, err, lat);
    check("tmo_err", err, 1);
    check("tmo_rsp", {lo, hi}, 0);
    check("tmo_valid_cyc", valid_cyc, 200);
    check("tmo_lat", lat, 201);
    check("tmo_hs_cnt", hs_q.size(), 0);
    check("tmo_stable", stab_err, 0);

    // low word answered, high word times out: low result discarded
    hs_allow = 1;
    run_req(2'b11, 1'b0, 5'b00001, 32'h00000010, 32'h00000010, 0, lo, hi, err, lat);
    check("tmo_hi_err", err, 1);
    check("tmo_hi_rsp", {lo, hi}, 0);
    check("tmo_hi_hs", enc_hs(hs_q), 4'b0010);
    check("tmo_hi_valid_cyc", valid_cyc, 201);

    // ready on the 200th cycle wins over the timeout
    hs_allow = 99; lat_fix = 199;
    run_req(2'b01, 1'b0, 5'b00001, 32'd7, 32'd6, 0, lo, hi, err, lat);
    check("edge_ok_err", err, 0);
    check("edge_ok_lo", lo, 32'd42);
    check("edge_ok_valid_cyc", valid_cyc, 200);
    // one cycle later is too late
    lat_fix = 200;
    run_req(2'b01, 1'b0, 5'b00001, 32'd7, 32'd6, 0, lo, hi, err, lat);
    check("edge_late_err", err, 1);
    check("edge_late_lo", lo, 0);
    check("edge_late_valid_cyc", valid_cyc, 200);

    // asynchronous reset while waiting in ISSUE_HI
    lat_fix = -1; hs_allow = 0;
    hs_q.delete(); hs_done = 0; valid_cyc = 0; stab_err = 0;
    req_if.req_op = 2'b10; req_if.req_clmul = 1'b1; req_if.req_pw = 5'b00010;
    req_if.req_crs1 = 32'hA5A5A5A5; req_if.req_crs2 = 32'h5A5A5A5A;
    req_if.req_valid = 1'b1;
    @(negedge clock);
    req_if.req_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("pre_rst_issue_hi", {mul_if.mul_valid, mul_if.mul_l, mul_if.mul_h}, 3'b101);
    #2 resetn = 1'b0;
    #1 check_reset("async_rst");
    @(negedge clock);
    resetn = 1'b1;
    hs_allow = 99;
    c1 = $urandom; c2 = $urandom;
    model_rsp(2'b11, 1'b0, 5'b00010, c1, c2, elo, ehi, eerr, ehs, ecnt);
    run_req(2'b11, 1'b0, 5'b00010, c1, c2, 1, lo, hi, err, lat);
    check("after_rst_lo", lo, elo);
    check("after_rst_hi", hi, ehi);
    check("after_rst_err", err, 0);
    check("after_rst_hs", enc_hs(hs_q), ehs);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
